// File: rtl/rotate_seq_ctrl.sv
// Command sequencer for a right-rotate register: one pattern load, then a
// counted train of rotate enables at a programmable spacing, with a shadow copy.
module rotate_seq_ctrl #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_data,
  input  logic [CW-1:0] cmd_count,
  input  logic [PW-1:0] cmd_period,
  input  logic          abort,
  output logic          load,
  output logic          en,
  output logic [DW-1:0] data,
  output logic [DW-1:0] shadow,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] pattern, pattern_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] period, period_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [DW-1:0] shadow_q, shadow_nxt;

  // State and datapath registers
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state    <= IDLE;
      pattern  <= '0;
      count    <= '0;
      period   <= '0;
      presc    <= '0;
      shadow_q <= '0;
    end else begin
      state    <= state_nxt;
      pattern  <= pattern_nxt;
      count    <= count_nxt;
      period   <= period_nxt;
      presc    <= presc_nxt;
      shadow_q <= shadow_nxt;
    end
  end

  // Next-state and datapath update; a pulse already presented in an abort
  // cycle still lands in the shadow.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    count_nxt   = count;
    period_nxt  = period;
    presc_nxt   = presc;
    shadow_nxt  = shadow_q;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          pattern_nxt = cmd_data;
          count_nxt   = cmd_count;
          period_nxt  = cmd_period;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        shadow_nxt = pattern;
        presc_nxt  = period;
        if (abort)
          state_nxt = IDLE;
        else if (count == CW'(0))
          state_nxt = DONE;
        else
          state_nxt = ROTATE;
      end
      ROTATE: begin
        if (presc == PW'(0)) begin
          shadow_nxt = {shadow_q[0], shadow_q[DW-1:1]};
          count_nxt  = count - CW'(1);
          presc_nxt  = period;
          if (abort)
            state_nxt = IDLE;
          else if (count == CW'(1))
            state_nxt = DONE;
        end else begin
          presc_nxt = presc - PW'(1);
          if (abort)
            state_nxt = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign load      = (state == LOAD);
  assign en        = (state == ROTATE) && (presc == PW'(0));
  assign data      = pattern;
  assign shadow    = shadow_q;

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl: table of commands with hand-computed
// results plus abort, busy-ignore and mid-sequence reset sequences.
module tb_rotate_seq_ctrl;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          async_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [CW-1:0] cmd_count;
  logic [PW-1:0] cmd_period;
  logic          abort;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] shadow;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotate_seq_ctrl #(.DW(DW), .CW(CW), .PW(PW)) dut (
    .clk(clk), .async_rst(async_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_period(cmd_period),
    .abort(abort), .load(load), .en(en), .data(data),
    .shadow(shadow), .busy(busy), .done(done)
  );

  typedef struct {
    logic [DW-1:0] cdata;
    logic [CW-1:0] count;
    logic [PW-1:0] period;
    logic [DW-1:0] exp_shadow;
    int            exp_ens;
    int            exp_done_idx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_load"},      32'(load),      32'd0);
    chk({tag, "_en"},        32'(en),        32'd0);
    chk({tag, "_data"},      32'(data),      32'd0);
    chk({tag, "_shadow"},    32'(shadow),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  // Issue one command and follow it to done; idx 0 is the LOAD cycle.
  task automatic run_vec(input vec_t v, input string tag);
    int idx, ens, first, last, gap_err, done_idx;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_data   = v.cdata;
    cmd_count  = v.count;
    cmd_period = v.period;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_data   = ~v.cdata;
    cmd_count  = CW'(1);
    cmd_period = PW'(0);
    chk({tag, "_load"},  32'(load),  32'd1);
    chk({tag, "_data"},  32'(data),  32'(v.cdata));
    chk({tag, "_busy"},  32'(busy),  32'd1);
    idx = 0; ens = 0; first = -1; last = -1; gap_err = 0; done_idx = -1;
    while (idx < 400) begin
      if (en) begin
        if (first < 0) first = idx;
        else if (idx - last != int'(v.period) + 1) gap_err++;
        last = idx;
        ens++;
      end
      if (done) begin
        done_idx = idx;
        break;
      end
      @(negedge clk);
      idx++;
    end
    chk({tag, "_done_idx"}, 32'(done_idx), 32'(v.exp_done_idx));
    chk({tag, "_en_count"}, 32'(ens),      32'(v.exp_ens));
    chk({tag, "_en_gap"},   32'(gap_err),  32'd0);
    if (ens > 0) chk({tag, "_first_en"}, 32'(first), 32'(int'(v.period) + 1));
    chk({tag, "_shadow"}, 32'(shadow), 32'(v.exp_shadow));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done),      32'd0);
    chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    int n, ens;
    logic seen_done;
    vecs[0] = '{4'b1000, 8'd3, 8'd0, 4'b0001, 3, 4};
    vecs[1] = '{4'b0001, 8'd5, 8'd2, 4'b1000, 5, 16};
    vecs[2] = '{4'b1010, 8'd0, 8'd7, 4'b1010, 0, 1};
    vecs[3] = '{4'b0110, 8'd4, 8'd1, 4'b0110, 4, 9};
    vecs[4] = '{4'b1101, 8'd2, 8'd3, 4'b0111, 2, 9};

    async_rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    cmd_count = '0; cmd_period = '0; abort = 1'b0;
    #1 async_rst = 1'b1;
    #1 chk_reset_outs("reset");
    @(negedge clk); async_rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("post_reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort on the 2nd enable while cmd_valid stays high with a new command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 4'b1000; cmd_count = 8'd6; cmd_period = 8'd1;
    @(negedge clk);
    cmd_data = 4'b0011; cmd_count = 8'd1; cmd_period = 8'd0;
    chk("abort_load", 32'(load), 32'd1);
    seen_done = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      chk($sformatf("abort_busy_%0d", i), 32'(cmd_ready), 32'd0);
    end
    chk("abort_en2", 32'(en), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_no_done", 32'({seen_done, done}), 32'd0);
    chk("abort_idle",    32'(busy),   32'd0);
    chk("abort_ready",   32'(cmd_ready), 32'd1);
    chk("abort_shadow",  32'(shadow), 32'(4'b0010));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_load", 32'(load), 32'd1);
    chk("held_data", 32'(data), 32'(4'b0011));
    n = 0; ens = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (en) ens++;
      n++;
    end
    chk("held_done",   32'(done),   32'd1);
    chk("held_ens",    32'(ens),    32'd1);
    chk("held_shadow", 32'(shadow), 32'(4'b1001));

    // Asynchronous reset in the middle of a rotate train
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 4'b0001; cmd_count = 8'd5; cmd_period = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_en", 32'(en), 32'd1);
    #2 async_rst = 1'b1;
    #1 chk_reset_outs("midrst");
    @(negedge clk); async_rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst_after");
    run_vec(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rotate_seq_ctrl.md
Name: rotate_seq_ctrl

Overview:
Upstream sequencer for the right-rotate register. Accepts a command (pattern, rotate count, step period) over a valid/ready handshake. Drives the register's load/en/data pins: one load of the pattern, then exactly the commanded number of rotate-enable pulses at a programmable spacing. Keeps a shadow copy of the expected register contents and pulses done when the sequence completes.

Parameters:
DW, 4, pattern / rotate register width
CW, 8, rotate count width
PW, 8, step period width (cycles between enables minus one)

Ports:
clk  input  1  clock, rising edge
async_rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  controller can accept command
cmd_data  input  DW  pattern to load
cmd_count  input  CW  number of right rotations
cmd_period  input  PW  enable spacing minus one
abort  input  1  terminate active sequence
load  output  1  to rotate register load
en  output  1  to rotate register en
data  output  DW  to rotate register data
shadow  output  DW  expected rotate register contents
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; pattern, count, period, prescaler and shadow regs = 0.
- Reset outputs: load=0, en=0, data=0, shadow=0, busy=0, done=0, cmd_ready=1.
- Reset asserted mid-sequence forces these values immediately, with no done pulse.
- States: IDLE, LOAD, ROTATE, DONE. All outputs are decodes of registered state; no input-to-output combinational path.
- cmd_ready=(state==IDLE); busy=(state!=IDLE); done=(state==DONE); load=(state==LOAD); data=latched pattern register.
- IDLE: on edge with cmd_valid&&cmd_ready, latch cmd_data, cmd_count, cmd_period, then go to LOAD. cmd_valid in any other state is ignored.
- LOAD: exactly one cycle with load=1. At the edge ending LOAD, shadow<=pattern and prescaler<=period.
- LOAD exit: count==0 -> DONE; else -> ROTATE.
- ROTATE: en=(prescaler==0).
- ROTATE, prescaler!=0: prescaler decrements.
- ROTATE, prescaler==0: shadow<={shadow[0],shadow[DW-1:1]}; count decrements; prescaler reloads period.
- ROTATE exit: when en fires with count==1, go to DONE.
- Enable timing: the first en falls period+1 cycles after entering ROTATE, and successive en pulses are period+1 cycles apart. period=0 gives en high on count consecutive cycles.
- DONE: one cycle, done=1, then IDLE. A new command can be accepted in the IDLE cycle that follows, so the minimum command spacing is 3 cycles for count=0.
- abort: sampled only in LOAD/ROTATE. Next state is IDLE with no done pulse.
  - If en (or load) is high in the abort cycle, that pulse has already been presented to the register, and shadow updates for it.
  - abort in IDLE/DONE has no effect.
- Count/period are latched values; changes to cmd_* after acceptance have no effect.
- shadow always equals the rotate register's q when both share clk/async_rst and the controller is the register's only driver.

Test Plan:
- Reset: assert async_rst between edges -> all outputs go to reset values immediately (cmd_ready=1); deassert -> IDLE.
- Basic: cmd_data=4'b1000, count=3, period=0 -> load high 1 cycle, then en high 3 consecutive cycles, shadow 1000->0100->0010->0001, done 1 cycle later, cmd_ready back to 1.
- Spacing and wrap: data=4'b0001, count=5, period=2 -> en pulses 3 cycles apart, 5 total, shadow ends 1000 (wrap through bit DW-1), done once.
- count=0: data=4'b1010 -> LOAD, DONE, IDLE; en never high; shadow=1010.
- Abort and busy-ignore: count=6, period=1; abort in the cycle of the 2nd en -> 2 rotations counted, no done, IDLE next; cmd_valid held during busy -> not accepted until cmd_ready.
- Mid-sequence reset: async_rst pulse during ROTATE -> shadow=0, en=0, busy=0 at once; the next command runs normally.
